// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/ack port between the MEM stage and data memory
interface mem_access_stage_if #(
    parameter int DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: branch resolve, req/ack data access, MEM/WB register
// Optional BUSY watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              write_reg_i,
    input  logic              write_back_i,
    input  logic              branch_i,
    input  logic              alu_zero_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [DATA_W-1:0] branch_target_i,
    input  logic [REG_AW-1:0] rt_or_rd_i,
    output logic              stall_o,
    output logic              pc_src_o,
    output logic [DATA_W-1:0] pc_target_o,
    mem_access_stage_if.master dmem,
    output logic              wb_valid_o,
    output logic              wb_reg_write_o,
    output logic              wb_mem_to_reg_o,
    output logic [REG_AW-1:0] wb_dest_o,
    output logic [DATA_W-1:0] wb_alu_result_o,
    output logic [DATA_W-1:0] wb_load_data_o,
    output logic              misalign_err_o,
    output logic              bus_err_o
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 256) begin : g_bad_timeout
        $error("TIMEOUT_CYC must lie in 2..256");
    end

    state_e state_q, state_d;

    logic              mem_op;
    logic              aligned;
    logic              accept;
    logic              timeout_hit;

    logic              dmem_req_q,     dmem_req_d;
    logic              dmem_we_q,      dmem_we_d;
    logic [DATA_W-1:0] dmem_addr_q,    dmem_addr_d;
    logic [DATA_W-1:0] dmem_wdata_q,   dmem_wdata_d;
    logic              lat_wreg_q,     lat_wreg_d;
    logic              lat_m2r_q,      lat_m2r_d;
    logic              lat_load_q,     lat_load_d;
    logic [REG_AW-1:0] lat_dest_q,     lat_dest_d;
    logic              wb_valid_q,     wb_valid_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic              wb_m2r_q,       wb_m2r_d;
    logic [REG_AW-1:0] wb_dest_q,      wb_dest_d;
    logic [DATA_W-1:0] wb_alu_q,       wb_alu_d;
    logic [DATA_W-1:0] wb_load_q,      wb_load_d;
    logic              misalign_q,     misalign_d;
    logic              bus_err_q,      bus_err_d;

    assign mem_op  = in_valid_i & (mem_read_i | mem_write_i);
    assign aligned = (alu_result_i[1:0] == 2'b00);
    assign accept  = (state_q == IDLE) & mem_op & aligned;

    assign pc_src_o    = in_valid_i & branch_i & alu_zero_i;
    assign pc_target_o = branch_target_i;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] to_cnt_q, to_cnt_d;

    // Held at zero outside BUSY, so it starts from zero on every entry.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == BUSY && !dmem.dmem_ack) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout_hit = (state_q == BUSY) && !dmem.dmem_ack
                         && (to_cnt_q == 8'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (dmem.dmem_ack || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o        = 1'b0;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        lat_wreg_d     = lat_wreg_q;
        lat_m2r_d      = lat_m2r_q;
        lat_load_d     = lat_load_q;
        lat_dest_d     = lat_dest_q;
        wb_valid_d     = wb_valid_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_m2r_d       = wb_m2r_q;
        wb_dest_d      = wb_dest_q;
        wb_alu_d       = wb_alu_q;
        wb_load_d      = wb_load_q;
        misalign_d     = 1'b0;
        bus_err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall_o        = 1'b1;
                    dmem_req_d     = 1'b1;
                    dmem_we_d      = mem_write_i;
                    dmem_addr_d    = alu_result_i;
                    dmem_wdata_d   = store_data_i;
                    lat_wreg_d     = write_reg_i;
                    lat_m2r_d      = write_back_i;
                    lat_load_d     = mem_read_i;
                    lat_dest_d     = rt_or_rd_i;
                    wb_valid_d     = 1'b0;
                    wb_reg_write_d = 1'b0;
                end else begin
                    // A misaligned access reaching here is retired as a squashed instruction.
                    wb_valid_d     = in_valid_i;
                    wb_reg_write_d = in_valid_i & write_reg_i & ~mem_op;
                    wb_m2r_d       = write_back_i;
                    wb_dest_d      = rt_or_rd_i;
                    wb_alu_d       = alu_result_i;
                    misalign_d     = mem_op;
                end
            end
            BUSY: begin
                if (dmem.dmem_ack) begin
                    dmem_req_d     = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = lat_wreg_q;
                    wb_m2r_d       = lat_m2r_q;
                    wb_dest_d      = lat_dest_q;
                    wb_alu_d       = dmem_addr_q;
                    if (lat_load_q) wb_load_d = dmem.dmem_rdata;
                end else if (timeout_hit) begin
                    dmem_req_d     = 1'b0;
                    bus_err_d      = 1'b1;
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = 1'b0;
                    wb_m2r_d       = lat_m2r_q;
                    wb_dest_d      = lat_dest_q;
                    wb_alu_d       = dmem_addr_q;
                end else begin
                    stall_o        = 1'b1;
                    wb_valid_d     = 1'b0;
                    wb_reg_write_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_wdata_q   <= '0;
            lat_wreg_q     <= 1'b0;
            lat_m2r_q      <= 1'b0;
            lat_load_q     <= 1'b0;
            lat_dest_q     <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_m2r_q       <= 1'b0;
            wb_dest_q      <= '0;
            wb_alu_q       <= '0;
            wb_load_q      <= '0;
            misalign_q     <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            lat_wreg_q     <= lat_wreg_d;
            lat_m2r_q      <= lat_m2r_d;
            lat_load_q     <= lat_load_d;
            lat_dest_q     <= lat_dest_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_m2r_q       <= wb_m2r_d;
            wb_dest_q      <= wb_dest_d;
            wb_alu_q       <= wb_alu_d;
            wb_load_q      <= wb_load_d;
            misalign_q     <= misalign_d;
            bus_err_q      <= bus_err_d;
        end
    end

    assign dmem.dmem_req   = dmem_req_q;
    assign dmem.dmem_we    = dmem_we_q;
    assign dmem.dmem_addr  = dmem_addr_q;
    assign dmem.dmem_wdata = dmem_wdata_q;

    assign wb_valid_o      = wb_valid_q;
    assign wb_reg_write_o  = wb_reg_write_q;
    assign wb_mem_to_reg_o = wb_m2r_q;
    assign wb_dest_o       = wb_dest_q;
    assign wb_alu_result_o = wb_alu_q;
    assign wb_load_data_o  = wb_load_q;
    assign misalign_err_o  = misalign_q;
    assign bus_err_o       = bus_err_q;
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM pipeline register.
- Resolves branches (PCSrc), drives a req/ack data-memory port for loads and stores, and stalls upstream while an access is outstanding.
- Registers results into the MEM/WB boundary for the write-back stage.

Parameters:
DATA_W, 32, data and address width
REG_AW, 5, destination register index width
TIMEOUT_CYC, 16, max BUSY cycles without ack (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EX/MEM holds a valid instruction
mem_read  in  1  load
mem_write  in  1  store
write_reg  in  1  instruction writes the register file
write_back  in  1  WB source select: 1 = load data, 0 = ALU result
branch  in  1  branch instruction
alu_zero  in  1  ALU zero flag
alu_result  in  DATA_W  ALU output, used as the memory address
store_data  in  DATA_W  store data (readData2)
branch_target  in  DATA_W  (PC+4)+imm<<2
rt_or_rd  in  REG_AW  destination register
stall  out  1  upstream must hold EX/MEM contents (comb)
pc_src  out  1  take branch (comb)
pc_target  out  DATA_W  branch target (comb)
dmem_req  out  1  memory request, registered
dmem_we  out  1  1 = write
dmem_addr  out  DATA_W  word address, bits[1:0]=0
dmem_wdata  out  DATA_W  write data
dmem_ack  in  1  access complete; read data valid this cycle
dmem_rdata  in  DATA_W  read data
wb_valid  out  1  MEM/WB holds a valid instruction
wb_reg_write  out  1  register-file write enable
wb_mem_to_reg  out  1  registered write_back
wb_dest  out  REG_AW  registered rt_or_rd
wb_alu_result  out  DATA_W  registered ALU result
wb_load_data  out  DATA_W  captured dmem_rdata
misalign_err  out  1  one-cycle pulse: load/store address bits[1:0] != 0
bus_err  out  1  one-cycle pulse on timeout (0 when the feature is absent)

Behaviour:
- Reset: state=IDLE. Every registered output is 0: dmem_*, wb_*, misalign_err, bus_err, and the timeout counter.
- Definitions: mem_op = in_valid & (mem_read | mem_write); aligned = alu_result[1:0]==0.
- pc_src = in_valid & branch & alu_zero; pc_target = branch_target. Both are combinational and independent of state.
- stall = (IDLE & mem_op & aligned) | (BUSY & !dmem_ack).
- IDLE, no mem_op: on the next edge MEM/WB loads the input values, with wb_valid=in_valid and wb_reg_write=in_valid&write_reg. Latency 1.
- IDLE, mem_op & aligned:
  - On the edge, latch dmem_addr=alu_result, dmem_wdata=store_data, dmem_we=mem_write, plus all control and dest fields.
  - Set dmem_req=1 and go to BUSY. wb_valid=0 (bubble).
- IDLE, mem_op & !aligned:
  - No request is issued; misalign_err pulses one cycle.
  - MEM/WB gets wb_valid=1 with wb_reg_write=0 (instruction squashed). No stall.
- BUSY & !dmem_ack: hold dmem_* stable; wb_valid=0.
- BUSY & dmem_ack:
  - On the edge, dmem_req=0 and wb_load_data=dmem_rdata (loads only; stores leave it unchanged).
  - MEM/WB loads the latched fields with wb_valid=1 and wb_reg_write=latched write_reg. Go to IDLE.
  - stall is already 0 in the ack cycle, so upstream advances on that same edge.
- Minimum memory-op occupancy is 2 cycles (accept, then ack in the first BUSY cycle).
- dmem_ack seen in IDLE is ignored.
- Back-to-back memory ops: the second is accepted in the cycle after return to IDLE.
- Async reset mid-access: dmem_req drops immediately, the access is discarded, and a later stray ack is ignored.
- The EX/MEM inputs are held by upstream while BUSY; the stage uses its latched copies, never the live inputs.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYC-1 without ack: dmem_req→0, bus_err pulses one cycle, MEM/WB gets wb_valid=1 with wb_reg_write=0, state→IDLE, and stall is 0 in that cycle.
- Undefined: the counter is absent, BUSY waits indefinitely, and bus_err is tied 0.

Test Plan:
- Reset: assert rst_n=0 mid-BUSY with dmem_req=1 → all outputs 0 asynchronously; ack 2 cycles after release → ignored, wb_valid stays 0.
- ALU op: in_valid=1, write_reg=1, alu_result=0x0000_1234, rt_or_rd=7 → next cycle wb_valid=1, wb_dest=7, wb_alu_result=0x1234, stall never asserted.
- Load with 3 wait states: mem_read, addr=0x100 → dmem_req rises next cycle with dmem_addr=0x100 and dmem_we=0. stall is high for 4 cycles. Ack with rdata=0xDEADBEEF → wb_load_data=0xDEADBEEF, wb_mem_to_reg=1.
- Store followed by load, ack in the first BUSY cycle each → dmem_we=1 with wdata=store_data, then dmem_we=0. Each op takes exactly 2 cycles; store wb_reg_write=0.
- Branch: branch=1, alu_zero=1, branch_target=0x40 → pc_src=1 with pc_target=0x40 the same cycle. With alu_zero=0 → pc_src=0.
- Misaligned load addr=0x102 → misalign_err 1-cycle pulse, no dmem_req, wb_reg_write=0. With MEM_TIMEOUT_EN and no ack → bus_err at cycle TIMEOUT_CYC=16 of BUSY, then back to IDLE.
